// File: rtl/tcdm_req_root_slice.sv
// Root slice of one bank's request arbitration tree: a 2-entry request buffer that
// decouples the bank grant from the tree, round-robin flag generation and response return.
module tcdm_req_root_slice #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH     = 16,
    parameter int unsigned N_MASTER     = 16,
    parameter int unsigned LOG_N_MASTER = $clog2(N_MASTER)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_add_i,
    input  logic                    data_wen_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    input  logic [BE_WIDTH-1:0]     data_be_i,
    input  logic [ID_WIDTH-1:0]     data_ID_i,
    output logic                    data_gnt_o,
    output logic [LOG_N_MASTER-1:0] RR_FLAG_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_add_o,
    output logic                    mem_wen_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [BE_WIDTH-1:0]     mem_be_o,
    input  logic                    mem_gnt_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    r_valid_o,
    output logic [ID_WIDTH-1:0]     r_ID_o,
    output logic [DATA_WIDTH-1:0]   r_rdata_o
);

    logic [1:0]            count_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [ADDR_WIDTH-1:0] add_q   [2];
    logic                  wen_q   [2];
    logic [DATA_WIDTH-1:0] wdata_q [2];
    logic [BE_WIDTH-1:0]   be_q    [2];
    logic [ID_WIDTH-1:0]   id_q    [2];
    logic [LOG_N_MASTER-1:0] rr_flag_q;
    logic                  r_valid_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic                  push;
    logic                  pop;

    // Grant and bank request come only from the registered fill level, so the
    // bank grant never reaches back into the tree combinationally.
    assign data_gnt_o = (count_q != 2'd2);
    assign mem_req_o  = (count_q != 2'd0);
    assign push       = data_req_i & data_gnt_o;
    assign pop        = mem_req_o & mem_gnt_i;

    assign mem_add_o   = add_q[rd_ptr_q];
    assign mem_wen_o   = wen_q[rd_ptr_q];
    assign mem_wdata_o = wdata_q[rd_ptr_q];
    assign mem_be_o    = be_q[rd_ptr_q];

    assign RR_FLAG_o = rr_flag_q;
    assign r_valid_o = r_valid_q;
    assign r_ID_o    = r_id_q;
    assign r_rdata_o = mem_rdata_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                add_q[i]   <= '0;
                wen_q[i]   <= 1'b0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
                id_q[i]    <= '0;
            end
        end else begin
            if (push) begin
                add_q[wr_ptr_q]   <= data_add_i;
                wen_q[wr_ptr_q]   <= data_wen_i;
                wdata_q[wr_ptr_q] <= data_wdata_i;
                be_q[wr_ptr_q]    <= data_be_i;
                id_q[wr_ptr_q]    <= data_ID_i;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (!push && pop) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    // The flag advances only on an accepted request, keeping the tree's
    // selection stable while the root is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_flag_q <= '0;
        end else if (push) begin
            rr_flag_q <= rr_flag_q + LOG_N_MASTER'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= pop;
            if (pop) begin
                r_id_q <= id_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_tcdm_req_root_slice.sv
// Directed self-checking bench for tcdm_req_root_slice: reset, reads, writes,
// stalls, streaming, round-robin wrap and mid-operation reset.
module tb_tcdm_req_root_slice;

    logic        clk;
    logic        rst_n;
    logic        data_req_i;
    logic [31:0] data_add_i;
    logic        data_wen_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_be_i;
    logic [15:0] data_ID_i;
    logic        data_gnt_o;
    logic [3:0]  RR_FLAG_o;
    logic        mem_req_o;
    logic [31:0] mem_add_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i;
    logic [31:0] mem_rdata_i;
    logic        r_valid_o;
    logic [15:0] r_ID_o;
    logic [31:0] r_rdata_o;

    int errors = 0;
    int checks = 0;

    tcdm_req_root_slice dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_req_i   (data_req_i),
        .data_add_i   (data_add_i),
        .data_wen_i   (data_wen_i),
        .data_wdata_i (data_wdata_i),
        .data_be_i    (data_be_i),
        .data_ID_i    (data_ID_i),
        .data_gnt_o   (data_gnt_o),
        .RR_FLAG_o    (RR_FLAG_o),
        .mem_req_o    (mem_req_o),
        .mem_add_o    (mem_add_o),
        .mem_wen_o    (mem_wen_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rdata_i  (mem_rdata_i),
        .r_valid_o    (r_valid_o),
        .r_ID_o       (r_ID_o),
        .r_rdata_o    (r_rdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; data_req_i = 1'b0; data_add_i = '0; data_wen_i = 1'b1;
        data_wdata_i = '0; data_be_i = '0; data_ID_i = '0; mem_gnt_i = 1'b0; mem_rdata_i = '0;
        #12;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req_o); end
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_gnt got %b want 1", data_gnt_o); end
        checks++; if (RR_FLAG_o !== 4'h0) begin errors++; $display("[TB] FAIL reset_rr got %h want 0", RR_FLAG_o); end
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_r_valid got %b want 0", r_valid_o); end
        checks++; if (r_ID_o !== 16'h0) begin errors++; $display("[TB] FAIL reset_r_id got %h want 0", r_ID_o); end
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset gnt=%b req=%b want gnt=1 req=0", data_gnt_o, mem_req_o); end
    endtask

    task automatic test_single_read;
        data_req_i = 1'b1; data_add_i = 32'h40; data_wen_i = 1'b1; data_ID_i = 16'h0004; mem_gnt_i = 1'b1;
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL read_gnt got %b want 1", data_gnt_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL read_no_bypass got %b want 0", mem_req_o); end
        tick;
        data_req_i = 1'b0;
        checks++; if (mem_req_o !== 1'b1 || mem_add_o !== 32'h40 || mem_wen_o !== 1'b1) begin errors++; $display("[TB] FAIL read_mem req=%b add=%h wen=%b want 1/40/1", mem_req_o, mem_add_o, mem_wen_o); end
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL read_early_valid got %b want 0", r_valid_o); end
        checks++; if (RR_FLAG_o !== 4'h1) begin errors++; $display("[TB] FAIL read_rr got %h want 1", RR_FLAG_o); end
        tick;
        mem_rdata_i = 32'hDEADBEEF;
        #1;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'h0004) begin errors++; $display("[TB] FAIL read_resp valid=%b id=%h want 1/0004", r_valid_o, r_ID_o); end
        checks++; if (r_rdata_o !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata got %h want deadbeef", r_rdata_o); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL read_drained got %b want 0", mem_req_o); end
        tick;
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL read_valid_pulse got %b want 0", r_valid_o); end
    endtask

    task automatic test_stall;
        mem_gnt_i = 1'b0;
        data_req_i = 1'b1; data_add_i = 32'h100; data_ID_i = 16'h0010;
        tick;
        data_add_i = 32'h104; data_ID_i = 16'h0020;
        checks++; if (data_gnt_o !== 1'b1 || mem_add_o !== 32'h100) begin errors++; $display("[TB] FAIL stall_second gnt=%b add=%h want 1/100", data_gnt_o, mem_add_o); end
        tick;
        data_add_i = 32'h108; data_ID_i = 16'h0040;
        checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_full_gnt got %b want 0", data_gnt_o); end
        tick;
        checks++; if (data_gnt_o !== 1'b0 || mem_req_o !== 1'b1 || mem_add_o !== 32'h100) begin errors++; $display("[TB] FAIL stall_hold gnt=%b req=%b add=%h want 0/1/100", data_gnt_o, mem_req_o, mem_add_o); end
        checks++; if (RR_FLAG_o !== 4'h3) begin errors++; $display("[TB] FAIL stall_rr got %h want 3", RR_FLAG_o); end
        mem_gnt_i = 1'b1;
        tick;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'h0010) begin errors++; $display("[TB] FAIL stall_pop0 valid=%b id=%h want 1/0010", r_valid_o, r_ID_o); end
        checks++; if (data_gnt_o !== 1'b1 || mem_add_o !== 32'h104) begin errors++; $display("[TB] FAIL stall_regrant gnt=%b add=%h want 1/104", data_gnt_o, mem_add_o); end
        tick;
        data_req_i = 1'b0;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'h0020 || mem_add_o !== 32'h108) begin errors++; $display("[TB] FAIL stall_pop1 valid=%b id=%h add=%h want 1/0020/108", r_valid_o, r_ID_o, mem_add_o); end
        tick;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'h0040 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_pop2 valid=%b id=%h req=%b want 1/0040/0", r_valid_o, r_ID_o, mem_req_o); end
        checks++; if (RR_FLAG_o !== 4'h4) begin errors++; $display("[TB] FAIL stall_rr_end got %h want 4", RR_FLAG_o); end
        tick;
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_idle got %b want 0", r_valid_o); end
    endtask

    task automatic test_streaming;
        mem_gnt_i = 1'b1; data_req_i = 1'b1; data_wen_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_ID_i = 16'(i + 1); data_add_i = 32'h200 + 32'(4 * i);
            checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL stream_gnt[%0d] got %b want 1", i, data_gnt_o); end
            if (i >= 1) begin
                checks++; if (mem_req_o !== 1'b1 || mem_add_o !== 32'h200 + 32'(4 * (i - 1))) begin errors++; $display("[TB] FAIL stream_mem[%0d] req=%b add=%h want 1/%h", i, mem_req_o, mem_add_o, 32'h200 + 32'(4 * (i - 1))); end
            end
            if (i >= 2) begin
                checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'(i - 1)) begin errors++; $display("[TB] FAIL stream_resp[%0d] valid=%b id=%h want 1/%h", i, r_valid_o, r_ID_o, 16'(i - 1)); end
            end
            tick;
        end
        data_req_i = 1'b0;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'd19) begin errors++; $display("[TB] FAIL stream_tail0 valid=%b id=%h want 1/0013", r_valid_o, r_ID_o); end
        tick;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'd20 || mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL stream_tail1 valid=%b id=%h req=%b want 1/0014/0", r_valid_o, r_ID_o, mem_req_o); end
        checks++; if (RR_FLAG_o !== 4'h8) begin errors++; $display("[TB] FAIL stream_rr got %h want 8", RR_FLAG_o); end
        tick;
    endtask

    task automatic test_write;
        mem_gnt_i = 1'b1; data_req_i = 1'b1; data_wen_i = 1'b0; data_be_i = 4'b0011;
        data_wdata_i = 32'h12345678; data_add_i = 32'h300; data_ID_i = 16'h0080;
        tick;
        data_req_i = 1'b0; data_wen_i = 1'b1; data_be_i = 4'hF; data_wdata_i = '0;
        checks++; if (mem_req_o !== 1'b1 || mem_wen_o !== 1'b0 || mem_be_o !== 4'h3 || mem_wdata_o !== 32'h12345678) begin errors++; $display("[TB] FAIL write_mem req=%b wen=%b be=%h wdata=%h want 1/0/3/12345678", mem_req_o, mem_wen_o, mem_be_o, mem_wdata_o); end
        tick;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'h0080) begin errors++; $display("[TB] FAIL write_resp valid=%b id=%h want 1/0080", r_valid_o, r_ID_o); end
        tick;
        checks++; if (r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL write_pulse got %b want 0", r_valid_o); end
    endtask

    task automatic test_rr_wrap;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (RR_FLAG_o !== 4'(i)) begin errors++; $display("[TB] FAIL rr_step[%0d] got %h want %h", i, RR_FLAG_o, 4'(i)); end
            data_req_i = 1'b1; data_ID_i = 16'(i);
            tick;
            data_req_i = 1'b0;
            tick;
        end
        checks++; if (RR_FLAG_o !== 4'h0) begin errors++; $display("[TB] FAIL rr_wrap got %h want 0", RR_FLAG_o); end
        tick;
        checks++; if (RR_FLAG_o !== 4'h0) begin errors++; $display("[TB] FAIL rr_idle_hold got %h want 0", RR_FLAG_o); end
    endtask

    task automatic test_mid_reset;
        mem_gnt_i = 1'b0; data_req_i = 1'b1; data_ID_i = 16'h0100; data_add_i = 32'h400;
        tick;
        data_ID_i = 16'h0200; data_add_i = 32'h404;
        tick;
        data_req_i = 1'b0;
        checks++; if (data_gnt_o !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_full gnt=%b req=%b want 0/1", data_gnt_o, mem_req_o); end
        mem_gnt_i = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req_o !== 1'b0 || r_valid_o !== 1'b0 || RR_FLAG_o !== 4'h0 || data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset req=%b valid=%b rr=%h gnt=%b want 0/0/0/1", mem_req_o, r_valid_o, RR_FLAG_o, data_gnt_o); end
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (r_valid_o !== 1'b0 || mem_req_o !== 1'b0 || data_gnt_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_no_stale[%0d] valid=%b req=%b gnt=%b want 0/0/1", i, r_valid_o, mem_req_o, data_gnt_o); end
        end
        data_req_i = 1'b1; data_ID_i = 16'h0300;
        tick;
        data_req_i = 1'b0;
        tick;
        checks++; if (r_valid_o !== 1'b1 || r_ID_o !== 16'h0300) begin errors++; $display("[TB] FAIL mid_inflight valid=%b id=%h want 1/0300", r_valid_o, r_ID_o); end
        rst_n = 1'b0;
        #1;
        checks++; if (r_valid_o !== 1'b0 || r_ID_o !== 16'h0) begin errors++; $display("[TB] FAIL mid_async_clear valid=%b id=%h want 0/0000", r_valid_o, r_ID_o); end
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (data_gnt_o !== 1'b1 || r_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_release gnt=%b valid=%b want 1/0", data_gnt_o, r_valid_o); end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_stall;
        test_streaming;
        test_write;
        test_rr_wrap;
        test_mid_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
